// File: rtl/pipe_control_hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl_pkg
// Brief   : Opcode/funct/ALU/forward encodings and the E-stage control bundle.
// Revision: 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam int ALU_W = 3;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef struct packed {
        logic             regwrite;
        logic             memtoreg;
        logic             memwrite;
        logic             alusrc;
        logic             regdst;
        logic [ALU_W-1:0] alucontrol;
    } ctrl_e_t;

endpackage
`default_nettype wire

// File: rtl/pipe_control_hazard_if.sv
`default_nettype none
// ============================================================================
// Module  : pipe_control_hazard_if
// Brief   : Datapath <-> control/hazard unit signal bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface pipe_control_hazard_if #(
    parameter int REGW  = 5,
    parameter int ALUCW = 3
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             equalD;
    logic [REGW-1:0]  rsD, rtD, rsE, rtE;
    logic [REGW-1:0]  writeregE, writeregM, writeregW;
    logic             pcsrcD, regdstE, alusrcE;
    logic [ALUCW-1:0] alucontrolE;
    logic             memwriteM, memtoregW, regwriteW;
    logic             stallF, stallD, flushE;
    logic             forwardAD, forwardBD;
    logic [1:0]       forwardAE, forwardBE;

    modport master (
        output op, funct, equalD, rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        input  pcsrcD, regdstE, alusrcE, alucontrolE, memwriteM, memtoregW, regwriteW,
        input  stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE
    );

    modport slave (
        input  op, funct, equalD, rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        output pcsrcD, regdstE, alusrcE, alucontrolE, memwriteM, memtoregW, regwriteW,
        output stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE
    );
endinterface
`default_nettype wire

// File: rtl/pipe_control_hazard_decode.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_decode
// Brief   : D-stage op/funct decoder producing the control bundle and branch.
// Revision: 1.0 - initial release
// ============================================================================
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  wire logic [5:0] i_op,
    input  wire logic [5:0] i_funct,
    output ctrl_e_t         o_ctrlD,
    output logic            o_branchD
);

    always_comb begin
        o_ctrlD   = '0;
        o_branchD = 1'b0;
        case (i_op)
            OP_RTYPE: begin
                o_ctrlD.regwrite = 1'b1;
                o_ctrlD.regdst   = 1'b1;
                case (i_funct)
                    FUNCT_ADD: o_ctrlD.alucontrol = ALU_ADD;
                    FUNCT_SUB: o_ctrlD.alucontrol = ALU_SUB;
                    FUNCT_AND: o_ctrlD.alucontrol = ALU_AND;
                    FUNCT_OR:  o_ctrlD.alucontrol = ALU_OR;
                    FUNCT_SLT: o_ctrlD.alucontrol = ALU_SLT;
                    default: begin
                        // Unsupported funct must not corrupt the register file
                        o_ctrlD.alucontrol = ALU_ADD;
                        o_ctrlD.regwrite   = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                o_ctrlD.regwrite   = 1'b1;
                o_ctrlD.alusrc     = 1'b1;
                o_ctrlD.memtoreg   = 1'b1;
                o_ctrlD.alucontrol = ALU_ADD;
            end
            OP_SW: begin
                o_ctrlD.memwrite   = 1'b1;
                o_ctrlD.alusrc     = 1'b1;
                o_ctrlD.alucontrol = ALU_ADD;
            end
            OP_BEQ: begin
                o_branchD          = 1'b1;
                o_ctrlD.alucontrol = ALU_SUB;
            end
            OP_ADDI: begin
                o_ctrlD.regwrite   = 1'b1;
                o_ctrlD.alusrc     = 1'b1;
                o_ctrlD.alucontrol = ALU_ADD;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pipe_control_hazard.sv
`default_nettype none
// ============================================================================
// Module  : pipe_control_hazard
// Brief   : Control pipeline (E/M/W), stall/flush and forwarding for 5-stage MIPS.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_control_hazard
    import pipe_ctrl_pkg::*;
#(
    parameter int REGW  = 5,
    parameter int ALUCW = 3
) (
    input  wire logic             clk,
    input  wire logic             reset,
    pipe_control_hazard_if.slave  bus
);

    localparam logic [REGW-1:0] c_zeroReg = '0;

    ctrl_e_t w_ctrlD;
    logic    w_branchD;
    ctrl_e_t r_ctrlE;
    logic    r_regwriteM, r_memtoregM, r_memwriteM;
    logic    r_regwriteW, r_memtoregW;
    logic    w_lwstall, w_branchstall, w_stall;

    ctrl_decode u_decode (
        .i_op      (bus.op),
        .i_funct   (bus.funct),
        .o_ctrlD   (w_ctrlD),
        .o_branchD (w_branchD)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrlE     <= '0;
            r_regwriteM <= 1'b0;
            r_memtoregM <= 1'b0;
            r_memwriteM <= 1'b0;
            r_regwriteW <= 1'b0;
            r_memtoregW <= 1'b0;
        end else begin
            r_ctrlE     <= w_stall ? '0 : w_ctrlD;
            r_regwriteM <= r_ctrlE.regwrite;
            r_memtoregM <= r_ctrlE.memtoreg;
            r_memwriteM <= r_ctrlE.memwrite;
            r_regwriteW <= r_regwriteM;
            r_memtoregW <= r_memtoregM;
        end
    end

    assign w_lwstall = r_ctrlE.memtoreg & ((bus.rtE == bus.rsD) | (bus.rtE == bus.rtD));

    // A branch compares in D, so any result still in E (or a load still in M) must wait
    assign w_branchstall = w_branchD &
        ((r_ctrlE.regwrite & ((bus.writeregE == bus.rsD) | (bus.writeregE == bus.rtD))) |
         (r_memtoregM      & ((bus.writeregM == bus.rsD) | (bus.writeregM == bus.rtD))));

    assign w_stall = w_lwstall | w_branchstall;

    assign bus.stallF = w_stall;
    assign bus.stallD = w_stall;
    assign bus.flushE = w_stall;
    assign bus.pcsrcD = w_branchD & bus.equalD & ~w_branchstall;

    assign bus.forwardAD = (bus.rsD != c_zeroReg) & (bus.rsD == bus.writeregM) & r_regwriteM;
    assign bus.forwardBD = (bus.rtD != c_zeroReg) & (bus.rtD == bus.writeregM) & r_regwriteM;

    // M is the younger result, so it wins over W
    always_comb begin
        bus.forwardAE = FWD_RF;
        bus.forwardBE = FWD_RF;
        if ((bus.rsE != c_zeroReg) & (bus.rsE == bus.writeregM) & r_regwriteM)
            bus.forwardAE = FWD_M;
        else if ((bus.rsE != c_zeroReg) & (bus.rsE == bus.writeregW) & r_regwriteW)
            bus.forwardAE = FWD_W;
        if ((bus.rtE != c_zeroReg) & (bus.rtE == bus.writeregM) & r_regwriteM)
            bus.forwardBE = FWD_M;
        else if ((bus.rtE != c_zeroReg) & (bus.rtE == bus.writeregW) & r_regwriteW)
            bus.forwardBE = FWD_W;
    end

    assign bus.regdstE     = r_ctrlE.regdst;
    assign bus.alusrcE     = r_ctrlE.alusrc;
    assign bus.alucontrolE = ALUCW'(r_ctrlE.alucontrol);
    assign bus.memwriteM   = r_memwriteM;
    assign bus.memtoregW   = r_memtoregW;
    assign bus.regwriteW   = r_regwriteW;

endmodule
`default_nettype wire

// File: tb/tb_pipe_control_hazard.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_control_hazard
// Brief   : Directed per-cycle vectors with a queued scoreboard and negedge monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipe_control_hazard;
    import pipe_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    pipe_control_hazard_if #(.REGW(5), .ALUCW(3)) bus ();

    pipe_control_hazard #(.REGW(5), .ALUCW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [17:0] expQ[$];
    string       nameQ[$];
    int          nApplied = 0;
    int          nMiss    = 0;

    localparam logic [17:0] Z = 18'd0;
    localparam logic [5:0]  OP_BAD = 6'b111111;

    function automatic logic [17:0] ex(input logic pc, input logic rdE, input logic asE,
                                       input logic [2:0] alu, input logic mwM, input logic mtW,
                                       input logic rwW, input logic st, input logic fad,
                                       input logic fbd, input logic [1:0] fae, input logic [1:0] fbe);
        return {pc, rdE, asE, alu, mwM, mtW, rwW, st, st, st, fad, fbd, fae, fbe};
    endfunction

    task automatic vec(input string nm, input logic rst, input logic [5:0] op,
                       input logic [5:0] fn, input logic eq, input logic [4:0] rsD,
                       input logic [4:0] rtD, input logic [4:0] rsE, input logic [4:0] rtE,
                       input logic [4:0] wE, input logic [4:0] wM, input logic [4:0] wW,
                       input logic [17:0] e);
        @(posedge clk);
        #1;
        reset         = rst;
        bus.op        = op;
        bus.funct     = fn;
        bus.equalD    = eq;
        bus.rsD       = rsD;
        bus.rtD       = rtD;
        bus.rsE       = rsE;
        bus.rtE       = rtE;
        bus.writeregE = wE;
        bus.writeregM = wM;
        bus.writeregW = wW;
        expQ.push_back(e);
        nameQ.push_back(nm);
    endtask

    // Monitor: every negedge with a pending vector, compare the whole output set
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            logic [17:0] act, e;
            string       nm;
            e  = expQ.pop_front();
            nm = nameQ.pop_front();
            act = {bus.pcsrcD, bus.regdstE, bus.alusrcE, bus.alucontrolE, bus.memwriteM,
                   bus.memtoregW, bus.regwriteW, bus.stallF, bus.stallD, bus.flushE,
                   bus.forwardAD, bus.forwardBD, bus.forwardAE, bus.forwardBE};
            nApplied++;
            if (act !== e) begin
                nMiss++;
                $display("FAIL %s: got %b required %b", nm, act, e);
            end
        end
    end

    initial begin
        //        name        rst op        funct      eq rsD rtD rsE rtE wE  wM  wW
        vec("rst0",       0, OP_RTYPE, FUNCT_ADD, 0, 1, 2, 0, 0, 0, 0, 0, Z);
        vec("rst1",       0, OP_RTYPE, FUNCT_ADD, 0, 1, 2, 0, 0, 0, 0, 0, Z);
        vec("rst2",       0, OP_RTYPE, FUNCT_ADD, 0, 1, 2, 0, 0, 0, 0, 0, Z);
        vec("release",    1, OP_RTYPE, FUNCT_ADD, 0, 1, 2, 0, 0, 0, 0, 0, Z);
        vec("addE",       1, OP_RTYPE, FUNCT_ADD, 0, 3, 0, 1, 2, 3, 0, 0,
            ex(0,1,0,ALU_ADD,0,0,0,0,0,0,FWD_RF,FWD_RF));
        vec("fwdM",       1, OP_RTYPE, FUNCT_ADD, 0, 3, 1, 3, 0, 7, 3, 0,
            ex(0,1,0,ALU_ADD,0,0,0,0,1,0,FWD_M,FWD_RF));
        vec("fwdW",       1, OP_RTYPE, FUNCT_ADD, 0, 1, 2, 3, 1, 8, 7, 3,
            ex(0,1,0,ALU_ADD,0,0,1,0,0,0,FWD_W,FWD_RF));
        vec("noFwd",      1, OP_RTYPE, FUNCT_ADD, 0, 0, 5, 1, 2, 0, 8, 7,
            ex(0,1,0,ALU_ADD,0,0,1,0,0,0,FWD_RF,FWD_RF));
        vec("zeroReg",    1, OP_LW,    6'd0,      0, 1, 5, 0, 5, 10, 0, 8,
            ex(0,1,0,ALU_ADD,0,0,1,0,0,0,FWD_RF,FWD_RF));
        vec("lwStall",    1, OP_RTYPE, FUNCT_ADD, 0, 5, 2, 1, 5, 5, 10, 0,
            ex(0,0,1,ALU_ADD,0,0,1,1,0,0,FWD_RF,FWD_RF));
        vec("bubble",     1, OP_RTYPE, FUNCT_ADD, 0, 5, 2, 0, 0, 0, 5, 10,
            ex(0,0,0,3'b000,0,0,1,0,1,0,FWD_RF,FWD_RF));
        vec("lwFwdW",     1, OP_RTYPE, FUNCT_ADD, 0, 1, 2, 5, 2, 11, 0, 5,
            ex(0,1,0,ALU_ADD,0,1,1,0,0,0,FWD_W,FWD_RF));
        vec("brStallE",   1, OP_BEQ,   6'd0,      1, 4, 0, 1, 2, 4, 11, 0,
            ex(0,1,0,ALU_ADD,0,0,0,1,0,0,FWD_RF,FWD_RF));
        vec("brTaken",    1, OP_BEQ,   6'd0,      1, 4, 0, 0, 0, 0, 4, 11,
            ex(1,0,0,3'b000,0,0,1,0,1,0,FWD_RF,FWD_RF));
        vec("brNotTaken", 1, OP_BEQ,   6'd0,      0, 4, 0, 4, 0, 0, 0, 4,
            ex(0,0,0,ALU_SUB,0,0,1,0,0,0,FWD_W,FWD_RF));
        vec("lw6D",       1, OP_LW,    6'd0,      0, 1, 6, 4, 0, 0, 0, 0,
            ex(0,0,0,ALU_SUB,0,0,0,0,0,0,FWD_RF,FWD_RF));
        vec("badOpD",     1, OP_BAD,   6'd0,      0, 0, 0, 1, 6, 6, 0, 0,
            ex(0,0,1,ALU_ADD,0,0,0,0,0,0,FWD_RF,FWD_RF));
        vec("brStallM",   1, OP_BEQ,   6'd0,      1, 0, 6, 0, 0, 0, 6, 0,
            ex(0,0,0,3'b000,0,0,0,1,0,1,FWD_RF,FWD_RF));
        vec("brAfterLw",  1, OP_BEQ,   6'd0,      1, 0, 6, 0, 0, 0, 0, 6,
            ex(1,0,0,3'b000,0,1,1,0,0,0,FWD_RF,FWD_RF));
        vec("badOpW",     1, OP_SW,    6'd0,      0, 1, 2, 0, 6, 0, 0, 0,
            ex(0,0,0,ALU_SUB,0,0,0,0,0,0,FWD_RF,FWD_RF));
        vec("swE",        1, OP_LW,    6'd0,      0, 1, 5, 1, 2, 0, 0, 0,
            ex(0,0,1,ALU_ADD,0,0,0,0,0,0,FWD_RF,FWD_RF));
        vec("dualStall",  1, OP_BEQ,   6'd0,      1, 5, 5, 1, 5, 5, 0, 0,
            ex(0,0,1,ALU_ADD,1,0,0,1,0,0,FWD_RF,FWD_RF));
        vec("rstMid0",    0, OP_BEQ,   6'd0,      0, 5, 5, 0, 0, 0, 5, 0, Z);
        vec("rstMid1",    0, OP_BEQ,   6'd0,      0, 5, 5, 0, 0, 0, 5, 0, Z);
        vec("noResidual", 1, OP_ADDI,  6'd0,      0, 0, 1, 0, 0, 0, 0, 0, Z);
        vec("addiE",      1, OP_RTYPE, 6'd0,      0, 0, 0, 0, 1, 1, 0, 0,
            ex(0,0,1,ALU_ADD,0,0,0,0,0,0,FWD_RF,FWD_RF));
        vec("badFunctE",  1, OP_BAD,   6'd0,      0, 0, 0, 0, 0, 0, 1, 0,
            ex(0,1,0,ALU_ADD,0,0,0,0,0,0,FWD_RF,FWD_RF));
        vec("addiW",      1, OP_BAD,   6'd0,      0, 0, 0, 0, 0, 0, 0, 1,
            ex(0,0,0,3'b000,0,0,1,0,0,0,FWD_RF,FWD_RF));
        vec("badFunctW",  1, OP_BAD,   6'd0,      0, 0, 0, 0, 0, 0, 0, 0, Z);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 4 && expQ.size() > 0; i++) @(posedge clk);
        if (expQ.size() > 0) begin
            nMiss++;
            $display("FAIL drain: got %0d pending required 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
